// File: rtl/dcf77_pkg.sv
// DCF77 transmitter shared definitions: frame bit positions,
// frame type, FSM state enum and the per-slot pulse rule.
package dcf77_pkg;

  localparam int FRAME_BITS = 59;
  localparam int SLOTS      = 10;

  localparam int DST_BIT   = 17;
  localparam int STD_BIT   = 18;
  localparam int BIT_START = 20;
  localparam int MIN_LSB   = 21;
  localparam int P1        = 28;
  localparam int HOUR_LSB  = 29;
  localparam int P2        = 35;
  localparam int DATE_LSB  = 36;
  localparam int P3        = 58;
  localparam int MARK      = 59;

  localparam int DATE_BITS = P3 - DATE_LSB;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Slot 0 always pulses, slot 1 carries the bit, second 59 is silent.
  function automatic logic pulse_on(
    input frame_t     f,
    input logic [5:0] sec,
    input logic [3:0] slot
  );
    logic on;
    on = 1'b0;
    if (sec < 6'(FRAME_BITS)) begin
      if (slot == 4'd0)
        on = 1'b1;
      else if (slot == 4'd1)
        on = f[sec];
    end
    return on;
  endfunction

endpackage

// File: rtl/dcf77_frame_build.sv
// Combinational DCF77 minute frame assembly with even parities.
// Shared with the decoder-side checker.
module dcf77_frame_build
  import dcf77_pkg::*;
(
  input  logic       dst,
  input  logic [6:0] minute_bcd,
  input  logic [5:0] hour_bcd,
  input  logic [5:0] day_bcd,
  input  logic [2:0] weekday,
  input  logic [4:0] month_bcd,
  input  logic [7:0] year_bcd,
  output frame_t     frame
);

  logic [DATE_BITS-1:0] date;

  assign date = {year_bcd, month_bcd, weekday, day_bcd};

  always_comb begin
    frame = '0;
    frame[DST_BIT]   = dst;
    frame[STD_BIT]   = ~dst;
    frame[BIT_START] = 1'b1;
    frame[MIN_LSB +: 7] = minute_bcd;
    frame[P1]           = ^minute_bcd;
    frame[HOUR_LSB +: 6] = hour_bcd;
    frame[P2]            = ^hour_bcd;
    frame[DATE_LSB +: DATE_BITS] = date;
    frame[P3]                    = ^date;
  end

endmodule

// File: rtl/dcf77_tx.sv
// DCF77 transmitter: prescaler, slot/second counters, frame register
// and PWM pulse generation from a 10 MHz clock.
module dcf77_tx
  import dcf77_pkg::*;
#(
  parameter int CLKS_PER_100MS = 1000000
) (
  input  logic       clk10,
  input  logic       reset,
  input  logic       enable,
  input  logic       dst,
  input  logic [6:0] minute_bcd,
  input  logic [5:0] hour_bcd,
  input  logic [5:0] day_bcd,
  input  logic [2:0] weekday,
  input  logic [4:0] month_bcd,
  input  logic [7:0] year_bcd,
  output logic       dcf_out,
  output logic [5:0] sec_count,
  output logic       min_mark
);

  localparam int PW = (CLKS_PER_100MS > 1) ? $clog2(CLKS_PER_100MS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_100MS - 1);
  localparam logic [3:0]    SLOT_MAX  = 4'(SLOTS - 1);
  localparam logic [5:0]    SEC_MAX   = 6'(MARK);

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    slot, slot_n;
  logic [5:0]    sec_n;
  frame_t        frame, frame_n;
  frame_t        built;
  logic          dcf_n;
  logic          mark_n;

  dcf77_frame_build u_build (
    .dst        (dst),
    .minute_bcd (minute_bcd),
    .hour_bcd   (hour_bcd),
    .day_bcd    (day_bcd),
    .weekday    (weekday),
    .month_bcd  (month_bcd),
    .year_bcd   (year_bcd),
    .frame      (built)
  );

  always_comb begin
    state_n = state;
    presc_n = presc;
    slot_n  = slot;
    sec_n   = sec_count;
    frame_n = frame;
    mark_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = RUN;
          presc_n = '0;
          slot_n  = '0;
          sec_n   = '0;
          frame_n = built;
          mark_n  = 1'b1;
        end
      end
      RUN: begin
        // Dropping enable wins over any wrap on the same edge.
        if (!enable) begin
          state_n = IDLE;
          presc_n = '0;
          slot_n  = '0;
          sec_n   = '0;
        end else if (presc == PRESC_MAX) begin
          presc_n = '0;
          if (slot == SLOT_MAX) begin
            slot_n = '0;
            if (sec_count == SEC_MAX) begin
              sec_n   = '0;
              frame_n = built;
              mark_n  = 1'b1;
            end else begin
              sec_n = sec_count + 6'd1;
            end
          end else begin
            slot_n = slot + 4'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        slot_n  = '0;
        sec_n   = '0;
      end
    endcase
    dcf_n = (state_n == RUN) && pulse_on(frame_n, sec_n, slot_n);
  end

  always_ff @(posedge clk10 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      slot      <= '0;
      sec_count <= '0;
      frame     <= '0;
      dcf_out   <= 1'b0;
      min_mark  <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      slot      <= slot_n;
      sec_count <= sec_n;
      frame     <= frame_n;
      dcf_out   <= dcf_n;
      min_mark  <= mark_n;
    end
  end

endmodule
